// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
//
// Bundles every signal between the load/store sequencer and its neighbours:
// the datapath request port, the doubleword memory port and the result port
// that feeds the downstream load extensor.
//
// Parameters:
//   MEM_AW      width of request and memory byte addresses
//
// Signals:
//   req_valid   request present
//   req_ready   sequencer idle; request accepted on req_valid & req_ready
//   req_store   1 = store, 0 = load
//   req_funct3  access size/sign code (b, h, w, d, bu, hu, wu)
//   req_addr    byte address
//   req_wdata   store data, right-justified
//   mem_addr    doubleword-aligned memory address
//   mem_rd      read strobe, held until mem_rvalid
//   mem_wr      single-cycle write strobe
//   mem_wdata   write data
//   mem_rdata   read data
//   mem_rvalid  mem_rdata valid
//   done        one-cycle completion pulse
//   misaligned  one-cycle error pulse (no memory access made)
//   ld_data     load data shifted down to bit 0, not yet extended
//   ld_select   funct3 of the captured load (extensor select)
//
// Modports:
//   slave   the sequencer itself (serves requests, drives the memory port)
//   master  the surrounding environment (datapath + memory)
// ---------------------------------------------------------------------------
interface mem_access_unit_if #(
    parameter int unsigned MEM_AW = 64
);

    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [MEM_AW-1:0] req_addr;
    logic [63:0]       req_wdata;

    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;
    logic              mem_rvalid;

    logic              done;
    logic              misaligned;
    logic [63:0]       ld_data;
    logic [2:0]        ld_select;

    modport slave (
        input  req_valid,
        input  req_store,
        input  req_funct3,
        input  req_addr,
        input  req_wdata,
        input  mem_rdata,
        input  mem_rvalid,
        output req_ready,
        output mem_addr,
        output mem_rd,
        output mem_wr,
        output mem_wdata,
        output done,
        output misaligned,
        output ld_data,
        output ld_select
    );

    modport master (
        output req_valid,
        output req_store,
        output req_funct3,
        output req_addr,
        output req_wdata,
        output mem_rdata,
        output mem_rvalid,
        input  req_ready,
        input  mem_addr,
        input  mem_rd,
        input  mem_wr,
        input  mem_wdata,
        input  done,
        input  misaligned,
        input  ld_data,
        input  ld_select
    );

endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Load/store sequencer between the datapath and a 64-bit doubleword data
// memory. Handles one request at a time:
//   - checks natural alignment; illegal requests pulse 'misaligned' and
//     never touch memory,
//   - loads read the doubleword and shift the addressed lane down to bit 0;
//     the raw result and funct3 go to the load extensor,
//   - sd writes directly, sb/sh/sw are read-modify-write.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    mem_access_unit_if.slave: request, memory and result signals
//
// Parameters:
//   MEM_AW width of request and memory addresses (must match the interface)
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned MEM_AW = 64
) (
    input logic              clk,
    input logic              reset,
    mem_access_unit_if.slave bus
);

    // -----------------------------------------------------------------------
    // State and registers
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StResp,
        StErr
    } state_e;

    state_e            state_q, state_d;

    // Latched request
    logic              store_q, store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;

    // Write data register: merged doubleword for sb/sh/sw, raw data for sd
    logic [63:0]       merge_q, merge_d;

    // Load result towards the extensor; only a load capture changes these
    logic [63:0]       ld_data_q, ld_data_d;
    logic [2:0]        ld_select_q, ld_select_d;

    // Decoded outputs
    logic              ready;
    logic              rd;
    logic              wr;
    logic              done_pulse;
    logic              mis_pulse;

    // -----------------------------------------------------------------------
    // Incoming request legality
    // -----------------------------------------------------------------------
    logic [2:0] req_off;
    logic       req_illegal;
    logic       req_is_sd;

    assign req_off   = bus.req_addr[2:0];
    assign req_is_sd = bus.req_store && (bus.req_funct3 == 3'b011);

    always_comb begin
        req_illegal = 1'b0;
        if (bus.req_funct3 == 3'b111) begin
            req_illegal = 1'b1;
        end else if (bus.req_store && bus.req_funct3[2]) begin
            // There are no unsigned stores
            req_illegal = 1'b1;
        end else begin
            // funct3[1:0] encodes the access size for both signed/unsigned
            unique case (bus.req_funct3[1:0])
                2'b00:   req_illegal = 1'b0;
                2'b01:   req_illegal = req_off[0];
                2'b10:   req_illegal = (req_off[1:0] != 2'b00);
                default: req_illegal = (req_off != 3'b000);
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Lane shift and read-modify-write merge for the latched request
    // -----------------------------------------------------------------------
    logic [5:0]  lane_shift;
    logic [63:0] size_mask;
    logic [63:0] lane_mask;
    logic [63:0] merged;
    logic [63:0] load_aligned;

    // Byte offset times eight
    assign lane_shift = {addr_q[2:0], 3'b000};

    always_comb begin
        size_mask = 64'h0;
        unique case (funct3_q[1:0])
            2'b00:   size_mask = 64'h0000_0000_0000_00ff;
            2'b01:   size_mask = 64'h0000_0000_0000_ffff;
            2'b10:   size_mask = 64'h0000_0000_ffff_ffff;
            default: size_mask = 64'hffff_ffff_ffff_ffff;
        endcase
    end

    assign lane_mask    = size_mask << lane_shift;
    assign merged       = (bus.mem_rdata & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
    assign load_aligned = bus.mem_rdata >> lane_shift;

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        merge_d     = merge_q;
        ld_data_d   = ld_data_q;
        ld_select_d = ld_select_q;

        ready      = 1'b0;
        rd         = 1'b0;
        wr         = 1'b0;
        done_pulse = 1'b0;
        mis_pulse  = 1'b0;

        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (bus.req_valid) begin
                    store_d  = bus.req_store;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    if (req_illegal) begin
                        state_d = StErr;
                    end else if (req_is_sd) begin
                        // Full doubleword: no read needed
                        merge_d = bus.req_wdata;
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end

            StRead: begin
                rd = 1'b1;
                if (bus.mem_rvalid) begin
                    if (store_q) begin
                        merge_d = merged;
                        state_d = StWrite;
                    end else begin
                        ld_data_d   = load_aligned;
                        ld_select_d = funct3_q;
                        state_d     = StResp;
                    end
                end
            end

            StWrite: begin
                wr      = 1'b1;
                state_d = StResp;
            end

            StResp: begin
                done_pulse = 1'b1;
                state_d    = StIdle;
            end

            StErr: begin
                mis_pulse = 1'b1;
                state_d   = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            store_q     <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= 64'h0;
            merge_q     <= 64'h0;
            ld_data_q   <= 64'h0;
            ld_select_q <= 3'b000;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            merge_q     <= merge_d;
            ld_data_q   <= ld_data_d;
            ld_select_q <= ld_select_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Strobes decode straight from state so reset drops them immediately.
    assign bus.req_ready  = ready;
    assign bus.mem_rd     = rd;
    assign bus.mem_wr     = wr;
    assign bus.done       = done_pulse;
    assign bus.misaligned = mis_pulse;

    assign bus.mem_addr   = {addr_q[MEM_AW-1:3], 3'b000};
    assign bus.mem_wdata  = merge_q;
    assign bus.ld_data    = ld_data_q;
    assign bus.ld_select  = ld_select_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//
// Scoreboard bench for mem_access_unit: each request pushes its expected
// write and completion events; a per-cycle sampler pops and compares them.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    typedef struct {
        int          cyc;
        logic [63:0] addr;
        logic [63:0] data;
    } wr_exp_t;

    typedef struct {
        bit          err;
        int          cyc;
        int          rd;
        logic [63:0] ld_data;
        logic [2:0]  ld_sel;
    } resp_exp_t;

    logic clk;
    logic reset;
    int   cyc;

    int n_tests;
    int n_fail;

    wr_exp_t   wr_q[$];
    resp_exp_t resp_q[$];

    // Bench-side state
    logic [63:0] mem_word;
    int          rv_delay;
    int          rd_wait;
    int          rd_cnt;
    int          t0;
    logic [63:0] cur_addr;
    logic [63:0] m_ld;
    logic [2:0]  m_sel;

    mem_access_unit_if #(.MEM_AW(64)) bus ();

    mem_access_unit #(.MEM_AW(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    function automatic bit model_illegal(input bit st, input logic [2:0] f3, input logic [2:0] off);
        int o;
        o = int'(off);
        if (f3 == 3'd7) return 1'b1;
        if (st && f3 >= 3'd4) return 1'b1;
        case (f3)
            3'd1, 3'd5: return (o % 2) != 0;
            3'd2, 3'd6: return (o % 4) != 0;
            3'd3:       return o != 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] w, input logic [2:0] off);
        logic [63:0] r;
        int o;
        r = 64'h0;
        o = int'(off);
        for (int i = 0; i < 8; i++) begin
            if (i + o < 8) r[i*8 +: 8] = w[(i+o)*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [63:0] model_merge(input logic [63:0] w, input logic [63:0] wd,
                                                input logic [2:0] off, input logic [2:0] f3);
        logic [63:0] r;
        int nb;
        int o;
        o  = int'(off);
        nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        r  = w;
        for (int i = 0; i < nb; i++) r[(o+i)*8 +: 8] = wd[i*8 +: 8];
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Per-cycle sampler (scoreboard pop side) and memory responder
    // -----------------------------------------------------------------------
    task automatic sample();
        wr_exp_t   w;
        resp_exp_t r;
        if (bus.mem_rd === 1'b1) begin
            rd_cnt++;
            check_eq("rd_addr", bus.mem_addr, cur_addr);
        end
        if (bus.mem_wr === 1'b1) begin
            if (wr_q.size() == 0) begin
                check_eq("unexpected_wr", 64'd1, 64'd0);
            end else begin
                w = wr_q.pop_front();
                check_eq("wr_cycle", 64'(cyc - t0), 64'(w.cyc));
                check_eq("wr_addr", bus.mem_addr, w.addr);
                check_eq("wr_data", bus.mem_wdata, w.data);
            end
        end
        if (bus.done === 1'b1 || bus.misaligned === 1'b1) begin
            if (resp_q.size() == 0) begin
                check_eq("unexpected_resp", 64'd1, 64'd0);
            end else begin
                r = resp_q.pop_front();
                check_eq("misaligned", 64'(bus.misaligned), 64'(r.err));
                check_eq("done", 64'(bus.done), 64'(!r.err));
                check_eq("resp_cycle", 64'(cyc - t0), 64'(r.cyc));
                check_eq("rd_cycles", 64'(rd_cnt), 64'(r.rd));
                check_eq("ld_data", bus.ld_data, r.ld_data);
                check_eq("ld_select", 64'(bus.ld_select), 64'(r.ld_sel));
                check_eq("ready_busy", 64'(bus.req_ready), 64'd0);
            end
            rd_cnt = 0;
        end
    endtask

    task automatic respond();
        bus.mem_rdata = {$urandom, $urandom};
        if (bus.mem_rd === 1'b1) begin
            if (rd_wait == rv_delay) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = mem_word;
                rd_wait        = 0;
            end else begin
                bus.mem_rvalid = 1'b0;
                rd_wait++;
            end
        end else begin
            // Stray rvalid while not reading must be ignored
            bus.mem_rvalid = ($urandom_range(0, 3) == 0);
            rd_wait        = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        respond();
    endtask

    // -----------------------------------------------------------------------
    // Request driver (scoreboard push side)
    // -----------------------------------------------------------------------
    task automatic run_req(input bit st, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] wd, input logic [63:0] word, input int dly);
        resp_exp_t   r;
        wr_exp_t     w;
        logic [2:0]  off;
        logic [63:0] al;
        int          n;
        off = addr[2:0];
        al  = {addr[63:3], 3'b000};
        r.err = 1'b0;
        if (model_illegal(st, f3, off)) begin
            r.err = 1'b1;
            r.cyc = 1;
            r.rd  = 0;
        end else if (!st) begin
            r.cyc = 2 + dly;
            r.rd  = dly + 1;
            m_ld  = model_load(word, off);
            m_sel = f3;
        end else if (f3 == 3'd3) begin
            w.cyc  = 1;
            w.addr = al;
            w.data = wd;
            wr_q.push_back(w);
            r.cyc = 2;
            r.rd  = 0;
        end else begin
            w.cyc  = 2 + dly;
            w.addr = al;
            w.data = model_merge(word, wd, off, f3);
            wr_q.push_back(w);
            r.cyc = 3 + dly;
            r.rd  = dly + 1;
        end
        r.ld_data = m_ld;
        r.ld_sel  = m_sel;
        resp_q.push_back(r);

        mem_word = word;
        rv_delay = dly;
        cur_addr = al;

        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        check_eq("ready_idle", 64'(bus.req_ready), 64'd1);
        t0 = cyc;
        tick();
        // Unit is busy now; scribble over the request fields
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = {$urandom, $urandom};
        bus.req_wdata  = {$urandom, $urandom};

        n = 0;
        while (resp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        if (resp_q.size() != 0) begin
            check_eq("resp_timeout", 64'd0, 64'd1);
            resp_q.delete();
            wr_q.delete();
        end
        check_eq("wr_pending", 64'(wr_q.size()), 64'd0);
        wr_q.delete();
        tick();
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rd_wait        = 0;
        rd_cnt         = 0;
        rv_delay       = 0;
        t0             = 0;
        mem_word       = 64'h0;
        cur_addr       = 64'h0;
        m_ld           = 64'h0;
        m_sel          = 3'd0;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 64'h0;
        bus.req_wdata  = 64'h0;
        bus.mem_rdata  = 64'h0;
        bus.mem_rvalid = 1'b0;

        #1;
        check_eq("rst_mem_rd", 64'(bus.mem_rd), 64'd0);
        check_eq("rst_mem_wr", 64'(bus.mem_wr), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_misaligned", 64'(bus.misaligned), 64'd0);
        check_eq("rst_ld_data", bus.ld_data, 64'd0);
        check_eq("rst_ld_select", 64'(bus.ld_select), 64'd0);
        check_eq("rst_mem_addr", bus.mem_addr, 64'd0);
        check_eq("rst_mem_wdata", bus.mem_wdata, 64'd0);
        repeat (3) tick();
        reset = 1'b0;
        check_eq("rst_ready", 64'(bus.req_ready), 64'd1);
        tick();

        // lb at offset 3
        run_req(1'b0, 3'b000, 64'h0000_1000_0000_0013, 64'h0, 64'h8877_6655_4433_2211, 0);
        // sb at offset 5
        run_req(1'b1, 3'b000, 64'h0000_1000_0000_0005, 64'h0000_0000_0000_00ab,
                64'h1111_1111_1111_1111, 0);
        // sd
        run_req(1'b1, 3'b011, 64'h0000_1000_0000_0008, 64'hdead_beef_cafe_f00d, 64'h0, 0);
        // Illegal: lw off 2, sh off 1, store funct3=100, load funct3=111
        run_req(1'b0, 3'b010, 64'h0000_1000_0000_0022, 64'h0, 64'h0123_4567_89ab_cdef, 0);
        run_req(1'b1, 3'b001, 64'h0000_1000_0000_0031, 64'h1234, 64'h0, 0);
        run_req(1'b1, 3'b100, 64'h0000_1000_0000_0040, 64'h55, 64'h0, 0);
        run_req(1'b0, 3'b111, 64'h0000_1000_0000_0048, 64'h0, 64'h0, 0);
        // lhu at offset 6 with three wait cycles
        run_req(1'b0, 3'b101, 64'h0000_1000_0000_0056, 64'h0, 64'hfedc_ba98_7654_3210, 3);
        // sh off 2, sw off 4 with a wait, ld, lwu, lbu
        run_req(1'b1, 3'b001, 64'h0000_2000_0000_0062, 64'hffff_ffff_ffff_beef,
                64'h0011_2233_4455_6677, 0);
        run_req(1'b1, 3'b010, 64'h0000_2000_0000_006c, 64'h1357_9bdf_0246_8ace,
                64'h0011_2233_4455_6677, 1);
        run_req(1'b0, 3'b011, 64'h0000_2000_0000_0070, 64'h0, 64'h8000_0000_0000_0001, 2);
        run_req(1'b0, 3'b110, 64'h0000_2000_0000_007c, 64'h0, 64'hcafe_babe_1234_5678, 0);
        run_req(1'b0, 3'b100, 64'h0000_2000_0000_0087, 64'h0, 64'ha5ff_ffff_ffff_ffff, 1);

        for (int i = 0; i < 24; i++) begin
            run_req(1'($urandom), 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom}, int'($urandom_range(0, 2)));
        end

        // Reset in the middle of an sw read phase
        mem_word       = 64'h5555_5555_5555_5555;
        rv_delay       = 5;
        cur_addr       = 64'h0000_3000_0000_0020;
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 64'h0000_3000_0000_0024;
        bus.req_wdata  = 64'h0000_0000_aaaa_aaaa;
        t0 = cyc;
        tick();
        bus.req_valid = 1'b0;
        tick();
        check_eq("pre_rst_mem_rd", 64'(bus.mem_rd), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_mem_rd", 64'(bus.mem_rd), 64'd0);
        check_eq("mid_rst_mem_wr", 64'(bus.mem_wr), 64'd0);
        check_eq("mid_rst_done", 64'(bus.done), 64'd0);
        check_eq("mid_rst_misaligned", 64'(bus.misaligned), 64'd0);
        check_eq("mid_rst_ld_data", bus.ld_data, 64'd0);
        check_eq("mid_rst_ld_select", 64'(bus.ld_select), 64'd0);
        check_eq("mid_rst_mem_addr", bus.mem_addr, 64'd0);
        check_eq("mid_rst_mem_wdata", bus.mem_wdata, 64'd0);
        m_ld   = 64'h0;
        m_sel  = 3'd0;
        rd_cnt = 0;
        repeat (2) tick();
        reset = 1'b0;
        check_eq("post_rst_ready", 64'(bus.req_ready), 64'd1);
        // Any write showing up here has no scoreboard entry and is flagged
        repeat (8) tick();
        run_req(1'b0, 3'b010, 64'h0000_3000_0000_0034, 64'h0, 64'h89ab_cdef_7654_3210, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed",
                 n_tests, n_fail);
        $fatal(1);
    end

endmodule
